rvm_alu_seq: RTL and testbench
==============================

Name: rvm_alu_seq

Overview:
- Sequencer for the integer ALU datapath of the multi-cycle core.
- Accepts one ALU operation per valid/ready request and decodes it onto the shared functional units: the bitwise unit rvm_bitwise, an add/sub/compare path, and an iterative shifter.
- Returns a registered result through a valid/ready response channel.
- Sits between the core control FSM and the register write-back mux.

Parameters:
- SHIFT_STEP, 1, maximum bit positions shifted per cycle by the iterative shifter; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_op  in  4  ALU op, encoding RVM_ALU_* in rvm_constants.v
- req_lhs  in  32  operand A
- req_rhs  in  32  operand B (shift amount = req_rhs[4:0])
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  32  result
- rsp_illegal  out  1  request op was not a legal encoding
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; rsp_valid=0, rsp_result=0, rsp_illegal=0, busy=0, req_ready=1.
  - Shift counter and operand registers cleared.
  - Reset mid-operation abandons the op; no response is ever produced for it.
- Ops: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, OR=5, AND=6, XOR=7, SLT=8, SLTU=9. Codes 10-15 are illegal.
- req_ready = (state==IDLE). A handshake occurs on a clk edge with req_valid & req_ready.
- FSM:
  - IDLE:
    - On handshake with a non-shift op: compute combinationally, register into rsp_result, go to DONE.
    - On handshake with a shift op and shamt==0: rsp_result=lhs, go to DONE.
    - On handshake with a shift op and shamt>0: load the shift register with lhs and the counter with shamt, go to SHIFT.
    - On handshake with an illegal op: rsp_result=0, rsp_illegal=1, go to DONE.
  - SHIFT:
    - Each cycle shift by min(SHIFT_STEP, counter); counter -= that amount.
    - SRA fills with the original bit 31.
    - When counter reaches 0 in this cycle, write the result and go to DONE.
  - DONE:
    - rsp_valid=1; rsp_result and rsp_illegal are held stable.
    - On rsp_ready: rsp_valid drops next cycle, rsp_illegal clears, go to IDLE.
    - No new request is accepted in the same cycle.
- Latency from the handshake edge to rsp_valid high:
  - 1 cycle for non-shift ops and shamt=0.
  - 1 + ceil(shamt/SHIFT_STEP) cycles for shifts.
- Maximum throughput: one op per 2 cycles.
- Bitwise unit op input is driven to BITWISE_NOP except in the IDLE handshake cycle for OR/AND/XOR, which isolates the unit when idle.
- SLT/SLTU: result is 32'd1 or 32'd0. ADD/SUB wrap modulo 2^32; no overflow flag.
- Response channel back-pressure is unbounded: the block stays in DONE while rsp_ready=0.
- Request inputs are sampled only at the handshake. Later changes to req_* do not affect an op in flight.

Optional Feature:
- Macro: RVM_ALU_SEQ_FAST_SHIFT_EN.
- When defined:
  - Shifts use a single-cycle barrel shifter in the IDLE handshake cycle.
  - The SHIFT state and counter are removed; every legal op has latency 1.
  - SHIFT_STEP is ignored.
- When undefined: iterative shifter as above.
- The response protocol is identical in both builds.

Decomposition:
- rvm_constants.v gains RVM_ALU_* op codes, RVM_ALU_OP_W=4, and the FSM state encodings RVM_ALU_SEQ_IDLE/SHIFT/DONE.
- The existing RVM_BITWISE_* codes are reused for the bitwise unit.
- One natural sub-module: rvm_shift_iter, holding the shift register, counter, per-step shift and done flag. The FSM and the add/compare logic stay in rvm_alu_seq.

Test Plan:
- Reset release, then ADD lhs=0xFFFFFFFF rhs=1 → rsp_valid one cycle after handshake, rsp_result=0x00000000, rsp_illegal=0.
- XOR lhs=0xF0F0F0F0 rhs=0xFF00FF00 → 0x0FF00FF0 at latency 1. OR gives 0xFFF0FFF0 and AND gives 0xF000F000.
- SRA lhs=0x80000000 rhs=31, SHIFT_STEP=1 → rsp_valid 32 cycles after handshake, result 0xFFFFFFFF. SHIFT_STEP=4 → 9 cycles. With the macro → 1 cycle.
- rsp_ready held 0 for 5 cycles in DONE → rsp_valid and result stable, req_ready=0. rsp_ready=1 → IDLE next cycle, req_ready=1.
- req_op=12 → rsp_illegal=1, rsp_result=0 at latency 1. rsp_illegal clears after the rsp handshake.
- resetn pulsed low during SLL rhs=20 in SHIFT → busy=0 and rsp_valid=0 immediately. A subsequent SLTU lhs=1 rhs=0xFFFFFFFF → result 1.

Source files
------------

// File: rtl/rvm_alu_seq_pkg.sv
// Shared types for the ALU sequencer: op codes, FSM state encodings and the
// bitwise unit (rvm_bitwise) op codes and evaluation function.
package rvm_alu_seq_pkg;

  localparam int RVM_ALU_OP_W = 4;

  typedef enum logic [RVM_ALU_OP_W-1:0] {
    RVM_ALU_ADD  = 4'd0,
    RVM_ALU_SUB  = 4'd1,
    RVM_ALU_SLL  = 4'd2,
    RVM_ALU_SRL  = 4'd3,
    RVM_ALU_SRA  = 4'd4,
    RVM_ALU_OR   = 4'd5,
    RVM_ALU_AND  = 4'd6,
    RVM_ALU_XOR  = 4'd7,
    RVM_ALU_SLT  = 4'd8,
    RVM_ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    RVM_ALU_SEQ_IDLE  = 2'd0,
    RVM_ALU_SEQ_SHIFT = 2'd1,
    RVM_ALU_SEQ_DONE  = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    RVM_BITWISE_NOP = 2'd0,
    RVM_BITWISE_OR  = 2'd1,
    RVM_BITWISE_AND = 2'd2,
    RVM_BITWISE_XOR = 2'd3
  } bitwise_op_e;

  // NOP yields zero so the unit's output is quiet whenever it is not selected.
  function automatic logic [31:0] rvm_bitwise(input bitwise_op_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    case (op)
      RVM_BITWISE_OR:  return a | b;
      RVM_BITWISE_AND: return a & b;
      RVM_BITWISE_XOR: return a ^ b;
      default:         return 32'd0;
    endcase
  endfunction

  function automatic logic is_shift_op(input logic [RVM_ALU_OP_W-1:0] op);
    return (op == RVM_ALU_SLL) || (op == RVM_ALU_SRL) || (op == RVM_ALU_SRA);
  endfunction

  function automatic logic is_legal_op(input logic [RVM_ALU_OP_W-1:0] op);
    return op <= RVM_ALU_SLTU;
  endfunction

endpackage

// File: rtl/rvm_alu_seq_shift_iter.sv
// Iterative shifter: shift register, remaining-count down-counter and a
// combinational done flag raised in the cycle whose step empties the counter.
module rvm_alu_seq_shift_iter #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        left,
  input  logic        arith,
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic [31:0] sh_q;
  logic [4:0]  cnt_q;
  logic        left_q;
  logic        fill_q;
  logic [4:0]  amt;
  logic [31:0] stepped;

  // Right shifts with a one-fill are done on the complement so SRA keeps
  // replicating the original sign bit across every step.
  always_comb begin
    amt = (cnt_q < STEP) ? cnt_q : STEP;
    if (left_q)
      stepped = sh_q << amt;
    else if (fill_q)
      stepped = ~(~sh_q >> amt);
    else
      stepped = sh_q >> amt;
  end

  assign done   = (cnt_q != 5'd0) && (cnt_q <= STEP);
  assign result = stepped;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_q   <= 32'd0;
      cnt_q  <= 5'd0;
      left_q <= 1'b0;
      fill_q <= 1'b0;
    end else if (start) begin
      sh_q   <= data;
      cnt_q  <= shamt;
      left_q <= left;
      fill_q <= arith & data[31];
    end else if (cnt_q != 5'd0) begin
      sh_q  <= stepped;
      cnt_q <= cnt_q - amt;
    end
  end

endmodule

// File: rtl/rvm_alu_seq.sv
// ALU sequencer: one op per request handshake, registered result on a
// valid/ready response. Define RVM_ALU_SEQ_FAST_SHIFT_EN for single-cycle shifts.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// SHIFT | iterative shifter stepping toward shamt
// DONE  | response valid, held until rsp_ready
module rvm_alu_seq
  import rvm_alu_seq_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_lhs,
  input  logic [31:0] req_rhs,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_illegal,
  output logic        busy
);

  seq_state_e  state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        illegal_q, illegal_d;

  logic        idle;
  logic [4:0]  shamt;
  bitwise_op_e bw_op;
  logic [31:0] bw_res;
  logic [32:0] diff;
  logic        lt_signed;
  logic [31:0] op_res;

  assign idle  = (state_q == RVM_ALU_SEQ_IDLE);
  assign shamt = req_rhs[4:0];

  // The bitwise unit only sees a real op during the accepting cycle.
  always_comb begin
    bw_op = RVM_BITWISE_NOP;
    if (idle && req_valid) begin
      case (req_op)
        RVM_ALU_OR:  bw_op = RVM_BITWISE_OR;
        RVM_ALU_AND: bw_op = RVM_BITWISE_AND;
        RVM_ALU_XOR: bw_op = RVM_BITWISE_XOR;
        default:     bw_op = RVM_BITWISE_NOP;
      endcase
    end
  end

  assign bw_res    = rvm_bitwise(bw_op, req_lhs, req_rhs);
  assign diff      = {1'b0, req_lhs} - {1'b0, req_rhs};
  assign lt_signed = (req_lhs[31] ^ req_rhs[31]) ? req_lhs[31] : diff[31];

  always_comb begin
    op_res = 32'd0;
    case (req_op)
      RVM_ALU_ADD:  op_res = req_lhs + req_rhs;
      RVM_ALU_SUB:  op_res = diff[31:0];
      RVM_ALU_SLT:  op_res = {31'd0, lt_signed};
      RVM_ALU_SLTU: op_res = {31'd0, diff[32]};
      RVM_ALU_OR, RVM_ALU_AND, RVM_ALU_XOR: op_res = bw_res;
`ifdef RVM_ALU_SEQ_FAST_SHIFT_EN
      RVM_ALU_SLL:  op_res = req_lhs << shamt;
      RVM_ALU_SRL:  op_res = req_lhs >> shamt;
      RVM_ALU_SRA:  op_res = $signed(req_lhs) >>> shamt;
`else
      RVM_ALU_SLL, RVM_ALU_SRL, RVM_ALU_SRA: op_res = req_lhs;
`endif
      default:      op_res = 32'd0;
    endcase
  end

`ifndef RVM_ALU_SEQ_FAST_SHIFT_EN
  logic        shift_start;
  logic        shift_done;
  logic [31:0] shift_result;

  rvm_alu_seq_shift_iter #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shift (
    .clk    (clk),
    .resetn (resetn),
    .start  (shift_start),
    .left   (req_op == RVM_ALU_SLL),
    .arith  (req_op == RVM_ALU_SRA),
    .data   (req_lhs),
    .shamt  (shamt),
    .done   (shift_done),
    .result (shift_result)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifndef RVM_ALU_SEQ_FAST_SHIFT_EN
    shift_start = 1'b0;
`endif
    case (state_q)
      RVM_ALU_SEQ_IDLE: begin
        if (req_valid) begin
          state_d = RVM_ALU_SEQ_DONE;
          if (!is_legal_op(req_op)) begin
            result_d  = 32'd0;
            illegal_d = 1'b1;
          end else begin
            result_d  = op_res;
            illegal_d = 1'b0;
`ifndef RVM_ALU_SEQ_FAST_SHIFT_EN
            if (is_shift_op(req_op) && (shamt != 5'd0)) begin
              shift_start = 1'b1;
              result_d    = result_q;
              state_d     = RVM_ALU_SEQ_SHIFT;
            end
`endif
          end
        end
      end
`ifndef RVM_ALU_SEQ_FAST_SHIFT_EN
      RVM_ALU_SEQ_SHIFT: begin
        if (shift_done) begin
          result_d = shift_result;
          state_d  = RVM_ALU_SEQ_DONE;
        end
      end
`endif
      RVM_ALU_SEQ_DONE: begin
        if (rsp_ready) begin
          illegal_d = 1'b0;
          state_d   = RVM_ALU_SEQ_IDLE;
        end
      end
      default: state_d = RVM_ALU_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RVM_ALU_SEQ_IDLE;
      result_q  <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign req_ready   = idle;
  assign busy        = !idle;
  assign rsp_valid   = (state_q == RVM_ALU_SEQ_DONE);
  assign rsp_result  = result_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_rvm_alu_seq.sv
// Self-checking bench for rvm_alu_seq: directed vector table, hand-written
// back-pressure and mid-op reset sequences, and randomized ops vs. a model.
module tb_rvm_alu_seq;

  localparam int STEP = 1;
`ifdef RVM_ALU_SEQ_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_lhs;
  logic [31:0] req_rhs;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rvm_alu_seq #(.SHIFT_STEP(STEP)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_lhs     (req_lhs),
    .req_rhs     (req_rhs),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_illegal (rsp_illegal),
    .busy        (busy)
  );

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return a >> sh;
      4'd4: return $signed(a) >>> sh;
      4'd5: return a | b;
      4'd6: return a & b;
      4'd7: return a ^ b;
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (!FAST && (op >= 4'd2) && (op <= 4'd4) && (sh != 0))
      return 1 + (sh + STEP - 1) / STEP;
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic exp_i,
                        input int exp_l, input int stall);
    int lat;
    @(negedge clk);
    chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_lhs   = a;
    req_rhs   = b;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      req_valid = 1'b0;
      req_op    = 4'($urandom);
      req_lhs   = $urandom;
      req_rhs   = $urandom;
    end while (!rsp_valid && lat < 300);
    if (!rsp_valid) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout actual=no_rsp_valid expected=rsp_valid_after_%0d", nm, exp_l);
      return;
    end
    chk({nm, "_lat"}, lat, exp_l);
    chk({nm, "_result"}, rsp_result, exp_r);
    chk({nm, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, exp_i});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk({nm, "_hold_flags"}, {29'd0, rsp_valid, req_ready, busy}, 32'b101);
      chk({nm, "_hold_result"}, rsp_result, exp_r);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, "_release"}, {28'd0, rsp_valid, req_ready, rsp_illegal, busy}, 32'b0100);
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          stall;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          saw_valid;

    vecs[0]  = '{"add_wrap",   4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 5};
    vecs[1]  = '{"xor",        4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 0};
    vecs[2]  = '{"or",         4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1, 0};
    vecs[3]  = '{"and",        4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 0};
    vecs[4]  = '{"sra31",      4'd4, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0,
                 FAST ? 1 : 1 + (31 + STEP - 1) / STEP, 0};
    vecs[5]  = '{"illegal12",  4'd12, 32'h1234_5678, 32'h9,        32'h0,         1'b1, 1, 2};
    vecs[6]  = '{"sub_wrap",   4'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1, 0};
    vecs[7]  = '{"slt_neg",    4'd8, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1, 0};
    vecs[8]  = '{"sltu_big",   4'd9, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0};
    vecs[9]  = '{"sll_shamt0", 4'd2, 32'hDEAD_BEEF, 32'h20,        32'hDEAD_BEEF, 1'b0, 1, 0};
    vecs[10] = '{"srl4",       4'd3, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0,
                 FAST ? 1 : 1 + (4 + STEP - 1) / STEP, 0};
    vecs[11] = '{"sll31",      4'd2, 32'h0000_0003, 32'd31,        32'h8000_0000, 1'b0,
                 FAST ? 1 : 1 + (31 + STEP - 1) / STEP, 1};
    vecs[12] = '{"illegal15",  4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 0};

    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_lhs   = 32'd0;
    req_rhs   = 32'd0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {29'd0, rsp_valid, req_ready, busy}, 32'b010);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_illegal", {31'd0, rsp_illegal}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].op, vecs[i].lhs, vecs[i].rhs, vecs[i].res,
             vecs[i].ill, vecs[i].lat, vecs[i].stall);

    // Reset while an SLL is in flight: nothing may come out for it afterwards.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd2;
    req_lhs   = 32'h0000_0001;
    req_rhs   = 32'd20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_busy_before", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("midreset_flags", {29'd0, busy, rsp_valid, req_ready}, 32'b001);
    chk("midreset_result", rsp_result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    saw_valid = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      saw_valid = saw_valid | rsp_valid;
    end
    chk("midreset_no_rsp", {31'd0, saw_valid}, 32'd0);
    run_op("sltu_after_reset", 4'd9, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (n % 4 == 0) a = {1'b1, a[30:0]};
      run_op($sformatf("rand%0d_op%0d", n, op), op, a, b, ref_res(op, a, b),
             op > 4'd9, ref_lat(op, b), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
